dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Two-requester arbiter and sequencer in front of the data memory (datamemory).
//  Port 0 is the core load/store unit; port 1 is a DMA/debug master. It grants
//  one access per cycle, drives MemRead/MemWrite/a/wd/Funct3, and returns load
//  data with fixed latency. Misaligned accesses are rejected before they reach memory.
// PARAMETERS
//  DM_ADDRESS   9   byte-address width presented to datamemory
//  DATA_W       32  data width
//  STARVE_LIMIT 4   consecutive lost cycles before port 1 beats port 0 (>=1)
// PORTS
//  clk           in   1           system clock; all state on posedge
//  reset         in   1           asynchronous, active-high reset
//  pN_req        in   1           N=0,1: access request, held until pN_gnt
//  pN_we         in   1           1=store, 0=load
//  pN_addr       in   DM_ADDRESS  byte address
//  pN_wdata      in   DATA_W      store data
//  pN_funct3     in   3           RV32 load/store width code
//  pN_gnt        out  1           request accepted this cycle (comb.)
//  pN_rvalid     out  1           one-cycle response pulse (loads and errors)
//  pN_rdata      out  DATA_W      load data, valid with pN_rvalid
//  pN_err        out  1           misaligned access, valid with pN_rvalid
//  mem_read      out  1           to datamemory MemRead
//  mem_write     out  1           to datamemory MemWrite
//  mem_a         out  DM_ADDRESS  to datamemory a
//  mem_wd        out  DATA_W      to datamemory wd
//  mem_funct3    out  3           to datamemory Funct3
//  mem_rd        in   DATA_W      from datamemory rd
// BEHAVIOUR
//  - Reset: issue and response stages invalid; all outputs 0; starve_cnt=0.
//    Reset mid-access drops in-flight request silently (no rvalid, no write).
//  - Pipeline: cycle T grant -> request captured in issue reg.
//    T+1 issue reg drives mem_*; mem_rd captured at end of T+1.
//    T+2 pN_rvalid for loads/errors. Stores produce no response unless err.
//  - Issue every cycle; back-to-back grants allowed, strictly in order, so
//    write at T+1 is visible to a read granted at T+1 (issued T+2).
//  - Arbitration (comb., from current req and starve_cnt):
//    one req -> grant it; both -> p0 unless starve_cnt==STARVE_LIMIT, then p1.
//  - starve_cnt: +1 when p1_req && !p1_gnt (saturates at STARVE_LIMIT);
//    cleared when p1_gnt or when !p1_req.
//  - Alignment: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0 are errors;
//    unknown funct3 codes are errors. An error access is granted, but issue
//    drives mem_read=mem_write=0; response at T+2 carries err=1, rdata=0.
//  - Idle issue stage: mem_read=mem_write=0, mem_a/mem_wd/mem_funct3 hold last.
//  - mem_read and mem_write are never both 1; mem_a is the full byte address
//    (datamemory does lane select).
//  - rdata passes through unchanged (datamemory performs extension).
//  - Only the granted port's rvalid/err may pulse; other port's outputs stay 0.
// STRUCTURE
//  - dmem_pkg: funct3 localparams (F3_B=000,F3_H=001,F3_W=010,F3_BU=100,
//    F3_HU=101), port-id enum {PORT_CORE,PORT_DMA}, issue-stage struct
//    {valid,port,we,err,addr,wdata,funct3}.
//  - Sub-module dmem_align_check: comb. (funct3, addr[1:0], we) -> err.
//  - Top holds arbiter, starve counter, issue and response registers.
// TESTING
//  1 p0 load LW addr 0x010 alone -> p0_gnt at T, mem_read=1 mem_a=0x010 at T+1,
//    p0_rvalid=1 p0_rdata=mem word at T+2, p0_err=0.
//  2 p0 SW 0xDEADBEEF @0x020 at T, p1 LW @0x020 at T+1 -> p1_rdata=0xDEADBEEF at T+3.
//  3 p0 and p1 req every cycle -> p0 wins 4 cycles, p1 wins 5th, pattern repeats.
//  4 p0 LW @0x013 -> granted, no mem_read at T+1, p0_rvalid=1 p0_err=1 rdata=0 at T+2;
//    p1 SH @0x011 -> mem_write stays 0, p1_err=1.
//  5 assert reset at T+1 after a store grant -> mem_write=0, no rvalid, starve_cnt=0.
//  6 p1 req drops after 2 lost cycles, reasserts -> counter restarts at 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: RV32 load/store width
// codes, requester identifiers and the issue-stage record.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 9;
    localparam int DMEM_DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DMA  = 1'b1
    } port_id_t;

    typedef struct packed {
        logic                   valid;
        port_id_t               port;
        logic                   we;
        logic                   err;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [2:0]             funct3;
    } issue_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of both requester ports plus the datamemory-facing signals.
interface dmem_port_arbiter_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  p0_req;
    logic                  p0_we;
    logic [DM_ADDRESS-1:0] p0_addr;
    logic [DATA_W-1:0]     p0_wdata;
    logic [2:0]            p0_funct3;
    logic                  p0_gnt;
    logic                  p0_rvalid;
    logic [DATA_W-1:0]     p0_rdata;
    logic                  p0_err;

    logic                  p1_req;
    logic                  p1_we;
    logic [DM_ADDRESS-1:0] p1_addr;
    logic [DATA_W-1:0]     p1_wdata;
    logic [2:0]            p1_funct3;
    logic                  p1_gnt;
    logic                  p1_rvalid;
    logic [DATA_W-1:0]     p1_rdata;
    logic                  p1_err;

    logic                  mem_read;
    logic                  mem_write;
    logic [DM_ADDRESS-1:0] mem_a;
    logic [DATA_W-1:0]     mem_wd;
    logic [2:0]            mem_funct3;
    logic [DATA_W-1:0]     mem_rd;

    // Arbiter side
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_funct3,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_funct3,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_read, mem_write, mem_a, mem_wd, mem_funct3,
        input  mem_rd
    );

    // Requesters plus memory model side
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_funct3,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_funct3,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_read, mem_write, mem_a, mem_wd, mem_funct3,
        output mem_rd
    );

endinterface

// File: rtl/dmem_align_check.sv
// Flags accesses whose width code is unknown for the direction or whose
// address is not naturally aligned for that width.
module dmem_align_check
    import dmem_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    input  logic       we,
    output logic       err
);

    always_comb begin
        err = 1'b1;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = addr_lo[0];
            F3_W:    err = |addr_lo;
            // Unsigned widths exist only for loads
            F3_BU:   err = we;
            F3_HU:   err = we | addr_lo[0];
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of datamemory: grant in cycle T, memory access in
// T+1, load/error response pulse in T+2. Port 1 wins after STARVE_LIMIT losses.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS   = 9,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    dmem_port_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
    logic              p1_wins;
    logic              any_req;
    logic              sel_we;
    logic [DM_ADDRESS-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        sel_funct3;
    logic              sel_err;

    issue_t            issue_reg, issue_next;

    logic              resp_valid_reg;
    port_id_t          resp_port_reg;
    logic              resp_err_reg;
    logic [DATA_W-1:0] resp_data_reg;

    always_comb begin
        any_req = bus.p0_req | bus.p1_req;
        p1_wins = bus.p1_req && (!bus.p0_req || (starve_cnt_reg == LIMIT_C));
    end

    assign bus.p0_gnt = bus.p0_req && !p1_wins;
    assign bus.p1_gnt = p1_wins;

    always_comb begin
        sel_we     = p1_wins ? bus.p1_we     : bus.p0_we;
        sel_addr   = p1_wins ? bus.p1_addr   : bus.p0_addr;
        sel_wdata  = p1_wins ? bus.p1_wdata  : bus.p0_wdata;
        sel_funct3 = p1_wins ? bus.p1_funct3 : bus.p0_funct3;
    end

    dmem_align_check u_align (
        .funct3  (sel_funct3),
        .addr_lo (sel_addr[1:0]),
        .we      (sel_we),
        .err     (sel_err)
    );

    // Any cycle port 1 is not waiting (granted or idle) restarts the count
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!bus.p1_req || p1_wins) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != LIMIT_C) begin
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
        end
    end

    // Idle cycles clear only valid so the memory-side fields hold their last value
    always_comb begin
        issue_next       = issue_reg;
        issue_next.valid = 1'b0;
        if (any_req) begin
            issue_next.valid  = 1'b1;
            issue_next.port   = p1_wins ? PORT_DMA : PORT_CORE;
            issue_next.we     = sel_we;
            issue_next.err    = sel_err;
            issue_next.addr   = DMEM_ADDR_W'(sel_addr);
            issue_next.wdata  = DMEM_DATA_W'(sel_wdata);
            issue_next.funct3 = sel_funct3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_reg <= '0;
            issue_reg      <= '0;
            resp_valid_reg <= 1'b0;
            resp_port_reg  <= PORT_CORE;
            resp_err_reg   <= 1'b0;
            resp_data_reg  <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            issue_reg      <= issue_next;
            resp_valid_reg <= issue_reg.valid && (!issue_reg.we || issue_reg.err);
            resp_port_reg  <= issue_reg.port;
            resp_err_reg   <= issue_reg.err;
            resp_data_reg  <= issue_reg.err ? '0 : bus.mem_rd;
        end
    end

    assign bus.mem_read   = issue_reg.valid && !issue_reg.we && !issue_reg.err;
    assign bus.mem_write  = issue_reg.valid &&  issue_reg.we && !issue_reg.err;
    assign bus.mem_a      = DM_ADDRESS'(issue_reg.addr);
    assign bus.mem_wd     = DATA_W'(issue_reg.wdata);
    assign bus.mem_funct3 = issue_reg.funct3;

    logic              rvalid_vec [2];
    logic              err_vec    [2];
    logic [DATA_W-1:0] rdata_vec  [2];

    // Response fields are gated so the non-addressed port reads all zeros
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign rvalid_vec[gi] = resp_valid_reg && (resp_port_reg == port_id_t'(gi));
        assign err_vec[gi]    = rvalid_vec[gi] && resp_err_reg;
        assign rdata_vec[gi]  = rvalid_vec[gi] ? resp_data_reg : '0;
    end

    assign bus.p0_rvalid = rvalid_vec[0];
    assign bus.p0_err    = err_vec[0];
    assign bus.p0_rdata  = rdata_vec[0];
    assign bus.p1_rvalid = rvalid_vec[1];
    assign bus.p1_err    = err_vec[1];
    assign bus.p1_rdata  = rdata_vec[1];

endmodule
